// File: rtl/morra_match_driver.sv
// rtl/morra_match_driver.sv - Morra Cinese match initiator: collects player moves, drives the game core, keeps score
module morra_match_driver #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] cfg_extra,
    input  logic [1:0] p1_move,
    input  logic       p1_valid,
    output logic       p1_ready,
    input  logic [1:0] p2_move,
    input  logic       p2_valid,
    output logic       p2_ready,
    output logic [1:0] primo,
    output logic [1:0] secondo,
    output logic       inizia,
    input  logic [1:0] manche,
    input  logic [1:0] partita,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic [1:0] winner,
    output logic [4:0] wins1,
    output logic [4:0] wins2,
    output logic [4:0] ties,
    output logic [4:0] rejected
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        COLLECT = 3'd2,
        PLAY    = 3'd3,
        CHECK   = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t        state, state_next;
    logic [3:0]    cfg_q;
    logic [1:0]    mv1, mv2;
    logic          have1, have2;
    logic          take1, take2;
    logic [TW-1:0] tcnt;

    function automatic logic [4:0] sat_inc(input logic [4:0] v);
        return (v == 5'd31) ? v : v + 5'd1;
    endfunction

    // A 00 move is never stored, so the player stays ready.
    assign take1 = (state == COLLECT) && !have1 && p1_valid && (p1_move != 2'b00);
    assign take2 = (state == COLLECT) && !have2 && p2_valid && (p2_move != 2'b00);

    always_comb begin
        state_next = state;
        primo      = 2'b00;
        secondo    = 2'b00;
        inizia     = 1'b0;
        p1_ready   = 1'b0;
        p2_ready   = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) state_next = INIT;
            end
            INIT: begin
                busy       = 1'b1;
                inizia     = 1'b1;
                primo      = cfg_q[3:2];
                secondo    = cfg_q[1:0];
                state_next = COLLECT;
            end
            COLLECT: begin
                busy     = 1'b1;
                p1_ready = !have1;
                p2_ready = !have2;
                // A move arriving on the final allowed cycle still starts the round.
                if ((have1 || take1) && (have2 || take2)) state_next = PLAY;
                else if (tcnt == TLAST)                   state_next = DONE;
            end
            PLAY: begin
                busy       = 1'b1;
                primo      = mv1;
                secondo    = mv2;
                state_next = CHECK;
            end
            CHECK: begin
                busy       = 1'b1;
                state_next = (partita != 2'b00) ? DONE : COLLECT;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cfg_q    <= 4'd0;
            mv1      <= 2'b00;
            mv2      <= 2'b00;
            have1    <= 1'b0;
            have2    <= 1'b0;
            tcnt     <= '0;
            done     <= 1'b0;
            timeout  <= 1'b0;
            winner   <= 2'b00;
            wins1    <= 5'd0;
            wins2    <= 5'd0;
            ties     <= 5'd0;
            rejected <= 5'd0;
        end else begin
            state <= state_next;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        cfg_q    <= cfg_extra;
                        mv1      <= 2'b00;
                        mv2      <= 2'b00;
                        have1    <= 1'b0;
                        have2    <= 1'b0;
                        done     <= 1'b0;
                        timeout  <= 1'b0;
                        winner   <= 2'b00;
                        wins1    <= 5'd0;
                        wins2    <= 5'd0;
                        ties     <= 5'd0;
                        rejected <= 5'd0;
                    end
                end
                INIT: tcnt <= '0;
                COLLECT: begin
                    tcnt <= tcnt + TW'(1);
                    if (take1) begin
                        mv1   <= p1_move;
                        have1 <= 1'b1;
                    end
                    if (take2) begin
                        mv2   <= p2_move;
                        have2 <= 1'b1;
                    end
                    if (state_next == DONE) begin
                        done    <= 1'b1;
                        timeout <= 1'b1;
                        winner  <= 2'b00;
                    end
                end
                PLAY: begin
                    case (manche)
                        2'b01:   wins1    <= sat_inc(wins1);
                        2'b10:   wins2    <= sat_inc(wins2);
                        2'b11:   ties     <= sat_inc(ties);
                        default: rejected <= sat_inc(rejected);
                    endcase
                    mv1   <= 2'b00;
                    mv2   <= 2'b00;
                    have1 <= 1'b0;
                    have2 <= 1'b0;
                end
                CHECK: begin
                    tcnt <= '0;
                    if (partita != 2'b00) begin
                        winner <= partita;
                        done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_morra_match_driver.sv
// tb/tb_morra_match_driver.sv - directed self-checking bench for morra_match_driver
module tb_morra_match_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] cfg_extra;
    logic [1:0] p1_move, p2_move;
    logic       p1_valid, p2_valid;
    logic       p1_ready, p2_ready;
    logic [1:0] primo, secondo;
    logic       inizia;
    logic [1:0] manche, partita;
    logic       busy, done, timeout;
    logic [1:0] winner;
    logic [4:0] wins1, wins2, ties, rejected;

    int errors = 0;
    int checks = 0;

    morra_match_driver #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_extra(cfg_extra),
        .p1_move(p1_move), .p1_valid(p1_valid), .p1_ready(p1_ready),
        .p2_move(p2_move), .p2_valid(p2_valid), .p2_ready(p2_ready),
        .primo(primo), .secondo(secondo), .inizia(inizia),
        .manche(manche), .partita(partita),
        .busy(busy), .done(done), .timeout(timeout), .winner(winner),
        .wins1(wins1), .wins2(wins2), .ties(ties), .rejected(rejected)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered while in COLLECT; leaves the bench one cycle after CHECK.
    task automatic play_round(input logic [1:0] m1, input logic [1:0] m2,
                              input logic [1:0] man, input logic [1:0] par, input string tag);
        p1_move = m1; p1_valid = 1'b1;
        p2_move = m2; p2_valid = 1'b1;
        manche  = man;
        step();
        p1_valid = 1'b0; p2_valid = 1'b0;
        chk({tag, "_play_primo"}, primo, m1);
        chk({tag, "_play_secondo"}, secondo, m2);
        chk({tag, "_play_ready"}, {p1_ready, p2_ready}, 0);
        step();
        manche  = 2'b00;
        partita = par;
        chk({tag, "_check_primo"}, primo, 0);
        step();
        partita = 2'b00;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cfg_extra = 4'd0;
        p1_move = 2'b00; p1_valid = 1'b0; p2_move = 2'b00; p2_valid = 1'b0;
        manche = 2'b00; partita = 2'b00;
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_inizia", inizia, 0);
        chk("rst_ready", {p1_ready, p2_ready}, 0);
        chk("rst_counters", {wins1, wins2, ties, rejected}, 0);
        rst_n = 1'b1;
        step();

        // match 1: four p1 wins, game ends with partita=10
        start = 1'b1; cfg_extra = 4'b0010;
        step();
        start = 1'b0; cfg_extra = 4'b1111;
        chk("init_inizia", inizia, 1);
        chk("init_primo", primo, 0);
        chk("init_secondo", secondo, 2);
        chk("init_busy", busy, 1);
        step();
        chk("collect_inizia", inizia, 0);
        chk("collect_ready", {p1_ready, p2_ready}, 3);
        play_round(2'b01, 2'b11, 2'b01, 2'b00, "r1");
        chk("r1_wins1", wins1, 1);
        chk("r1_back_collect", {busy, p1_ready, p2_ready}, 7);
        play_round(2'b10, 2'b01, 2'b01, 2'b00, "r2");
        chk("r2_wins1", wins1, 2);
        play_round(2'b11, 2'b10, 2'b01, 2'b00, "r3");
        chk("r3_wins1", wins1, 3);
        start = 1'b1;
        play_round(2'b01, 2'b11, 2'b01, 2'b10, "r4");
        start = 1'b0;
        chk("m1_wins1", wins1, 4);
        chk("m1_done", done, 1);
        chk("m1_winner", winner, 2);
        chk("m1_busy", busy, 0);
        chk("m1_timeout", timeout, 0);
        step();
        chk("m1_done_held", {done, winner}, 6);

        // match 2: repeated winning move is rejected
        start = 1'b1; cfg_extra = 4'b0000;
        step();
        start = 1'b0;
        chk("m2_cleared", {done, winner, wins1}, 0);
        step();
        play_round(2'b01, 2'b11, 2'b01, 2'b00, "rep1");
        play_round(2'b01, 2'b11, 2'b00, 2'b00, "rep2");
        chk("rep_rejected", rejected, 1);
        chk("rep_wins1", wins1, 1);
        chk("rep_collect", {busy, p1_ready, p2_ready}, 7);

        // 00 move discarded, p2 arrives 5 cycles after p1's first valid
        p1_valid = 1'b1; p1_move = 2'b00;
        step();
        chk("disc_p1_ready", p1_ready, 1);
        p1_move = 2'b01;
        step();
        p1_valid = 1'b0;
        chk("cap_p1_ready", p1_ready, 0);
        chk("cap_p2_ready", p2_ready, 1);
        step(); step(); step();
        chk("wait_busy", {busy, p2_ready}, 3);
        p2_valid = 1'b1; p2_move = 2'b11; manche = 2'b11;
        step();
        p2_valid = 1'b0;
        chk("late_play_primo", primo, 1);
        chk("late_play_secondo", secondo, 3);
        step();
        manche = 2'b00;
        step();
        chk("late_ties", ties, 1);
        chk("late_collect", {p1_ready, p2_ready}, 3);

        // timeout: only p1 moves, 8 COLLECT cycles
        p1_valid = 1'b1; p1_move = 2'b10;
        step();
        p1_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("to_before", {busy, done}, 2);
        step();
        chk("to_done", done, 1);
        chk("to_timeout", timeout, 1);
        chk("to_winner", winner, 0);
        chk("to_busy", busy, 0);
        chk("to_ties_held", ties, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_timeout", {timeout, done}, 0);
        chk("restart_counters", {wins1, ties, rejected}, 0);

        // reset mid-COLLECT with p1 captured, start held through reset
        step();
        p1_valid = 1'b1; p1_move = 2'b11;
        step();
        p1_valid = 1'b0;
        chk("pre_rst_p1_ready", p1_ready, 0);
        rst_n = 1'b0; start = 1'b1;
        #1;
        chk("mid_rst_outputs", {busy, inizia, p1_ready, p2_ready, primo, secondo}, 0);
        step();
        chk("rst_start_busy", busy, 0);
        #2;
        rst_n = 1'b1; start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_idle", {inizia, busy}, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
